// File: rtl/lcd_read_if.sv
// rtl/lcd_read_if.sv - request/response and LCD pin bundle for the LCD read FSM
interface lcd_read_if;
    logic       start;
    logic       rs_sel;
    logic       poll;
    logic [3:0] SF_D_in;
    logic       LCD_E;
    logic       LCD_RS;
    logic       LCD_RW;
    logic       bus_release;
    logic [7:0] data_out;
    logic       busy_flag;
    logic       done;
    logic       timeout;
    logic       busy;

    modport master (
        output start, rs_sel, poll, SF_D_in,
        input  LCD_E, LCD_RS, LCD_RW, bus_release, data_out, busy_flag, done, timeout, busy
    );

    modport slave (
        input  start, rs_sel, poll, SF_D_in,
        output LCD_E, LCD_RS, LCD_RW, bus_release, data_out, busy_flag, done, timeout, busy
    );
endinterface

// File: rtl/lcd_read_fsm.sv
// rtl/lcd_read_fsm.sv - two-nibble LCD read transaction with optional busy-flag polling
module lcd_read_fsm #(
    parameter int SETUP_CYC    = 2,
    parameter int E_CYC        = 12,
    parameter int HOLD_CYC     = 1,
    parameter int GAP_CYC      = 50,
    parameter int RECOVER_CYC  = 2000,
    parameter int POLL_GAP_CYC = 50,
    parameter int MAX_POLLS    = 255
) (
    input  logic     clk,
    input  logic     reset,
    lcd_read_if.slave bus
);

    localparam int M1   = (SETUP_CYC > E_CYC) ? SETUP_CYC : E_CYC;
    localparam int M2   = (M1 > HOLD_CYC) ? M1 : HOLD_CYC;
    localparam int M3   = (M2 > GAP_CYC) ? M2 : GAP_CYC;
    localparam int M4   = (M3 > RECOVER_CYC) ? M3 : RECOVER_CYC;
    localparam int MAXP = (M4 > POLL_GAP_CYC) ? M4 : POLL_GAP_CYC;
    localparam int CWR  = $clog2(MAXP + 1);
    localparam int CW   = (CWR > 12) ? CWR : 12;

    typedef enum logic [3:0] {
        IDLE, SETUP_HI, E_HI, HOLD_HI, GAP, SETUP_LO, E_LO, HOLD_LO, POLLWAIT, RECOVER, DONE
    } state_t;

    state_t        state, nxt;
    logic [CW-1:0] cnt, cnt_d;
    logic [7:0]    poll_cnt;
    logic          rs_q, poll_q, to_q;
    logic [7:0]    data_q;
    logic          bf_q;
    logic          last, cap_hi, cap_lo, inc_poll, set_to, active;

    // Counter reload value for a state: its duration minus one, counted down to zero.
    function automatic logic [CW-1:0] reload(input state_t s);
        case (s)
            SETUP_HI, SETUP_LO: reload = CW'(SETUP_CYC - 1);
            E_HI, E_LO:         reload = CW'(E_CYC - 1);
            HOLD_HI, HOLD_LO:   reload = CW'(HOLD_CYC - 1);
            GAP:                reload = CW'(GAP_CYC - 1);
            POLLWAIT:           reload = CW'(POLL_GAP_CYC - 1);
            RECOVER:            reload = CW'(RECOVER_CYC - 1);
            default:            reload = '0;
        endcase
    endfunction

    // Next-state, counter and capture/poll strobes.
    always_comb begin
        nxt      = state;
        last     = (cnt == '0);
        cnt_d    = last ? '0 : cnt - CW'(1);
        cap_hi   = 1'b0;
        cap_lo   = 1'b0;
        inc_poll = 1'b0;
        set_to   = 1'b0;
        case (state)
            IDLE:     if (bus.start) nxt = SETUP_HI;
            SETUP_HI: if (last) nxt = E_HI;
            E_HI:     if (last) begin nxt = HOLD_HI; cap_hi = 1'b1; end
            HOLD_HI:  if (last) nxt = GAP;
            GAP:      if (last) nxt = SETUP_LO;
            SETUP_LO: if (last) nxt = E_LO;
            E_LO:     if (last) begin nxt = HOLD_LO; cap_lo = 1'b1; end
            HOLD_LO: begin
                if (last) begin
                    if (rs_q)                       nxt = RECOVER;
                    else if (!poll_q || !data_q[7]) nxt = DONE;
                    else if (poll_cnt < 8'(MAX_POLLS)) begin
                        nxt      = POLLWAIT;
                        inc_poll = 1'b1;
                    end else begin
                        nxt    = DONE;
                        set_to = 1'b1;
                    end
                end
            end
            POLLWAIT: if (last) nxt = SETUP_HI;
            RECOVER:  if (last) nxt = DONE;
            DONE:     nxt = IDLE;
            default:  nxt = IDLE;
        endcase
        if (nxt != state) cnt_d = reload(nxt);
    end

    // State, counters, latched request and assembled byte.
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            cnt      <= '0;
            poll_cnt <= '0;
            rs_q     <= 1'b0;
            poll_q   <= 1'b0;
            to_q     <= 1'b0;
            data_q   <= 8'h00;
            bf_q     <= 1'b0;
        end else begin
            state <= nxt;
            cnt   <= cnt_d;
            if (state == IDLE && bus.start) begin
                rs_q     <= bus.rs_sel;
                poll_q   <= bus.poll & ~bus.rs_sel;
                poll_cnt <= 8'd1;
                to_q     <= 1'b0;
            end
            if (inc_poll) poll_cnt <= poll_cnt + 8'd1;
            if (set_to)   to_q <= 1'b1;
            if (cap_hi)   data_q[7:4] <= bus.SF_D_in;
            if (cap_lo)   data_q[3:0] <= bus.SF_D_in;
            if (nxt == DONE && state != DONE && !rs_q) bf_q <= data_q[7];
        end
    end

    // Pin and status outputs decoded from state; RS/RW/tristate held for the whole transfer.
    always_comb begin
        active          = (state != IDLE) && (state != DONE);
        bus.LCD_E       = (state == E_HI) || (state == E_LO);
        bus.LCD_RW      = active;
        bus.bus_release = active;
        bus.LCD_RS      = active & rs_q;
        bus.busy        = (state != IDLE);
        bus.done        = (state == DONE);
        bus.timeout     = (state == DONE) & to_q;
        bus.data_out    = data_q;
        bus.busy_flag   = bf_q;
    end

endmodule

// File: tb/tb_lcd_read_fsm.sv
// tb/tb_lcd_read_fsm.sv - randomized self-checking bench for lcd_read_fsm
module tb_lcd_read_fsm;

    localparam int T_NIB  = 2 + 12 + 1;
    localparam int T_GAP  = 50;
    localparam int T_POLL = 50;
    localparam int T_REC  = 2000;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #10 clk = ~clk;

    bit         sel = 1'b0;
    logic       st = 1'b0, rs = 1'b0, pl = 1'b0;
    logic [3:0] sf = 4'h0;

    lcd_read_if b0 ();
    lcd_read_if b1 ();

    assign b0.start = st & ~sel;
    assign b1.start = st & sel;
    assign b0.rs_sel = rs;
    assign b1.rs_sel = rs;
    assign b0.poll = pl;
    assign b1.poll = pl;
    assign b0.SF_D_in = sf;
    assign b1.SF_D_in = sf;

    lcd_read_fsm u_dut (.clk(clk), .reset(reset), .bus(b0));
    lcd_read_fsm #(.MAX_POLLS(4)) u_dut4 (.clk(clk), .reset(reset), .bus(b1));

    logic m_e, m_rs, m_rw, m_rel, m_bf, m_done, m_to, m_busy;
    logic [7:0] m_data;
    always_comb begin
        m_e    = sel ? b1.LCD_E       : b0.LCD_E;
        m_rs   = sel ? b1.LCD_RS      : b0.LCD_RS;
        m_rw   = sel ? b1.LCD_RW      : b0.LCD_RW;
        m_rel  = sel ? b1.bus_release : b0.bus_release;
        m_bf   = sel ? b1.busy_flag   : b0.busy_flag;
        m_done = sel ? b1.done        : b0.done;
        m_to   = sel ? b1.timeout     : b0.timeout;
        m_busy = sel ? b1.busy        : b0.busy;
        m_data = sel ? b1.data_out    : b0.data_out;
    end

    int checks = 0;
    int errors = 0;
    bit bf_model [2];
    logic [3:0] nib_hi [$];
    logic [3:0] nib_lo [$];

    task automatic check(input string tag, input int obs, input int exp);
        checks++;
        if (obs != exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic check_zero(input string pre);
        check({pre, "_e"}, m_e, 0);
        check({pre, "_rs"}, m_rs, 0);
        check({pre, "_rw"}, m_rw, 0);
        check({pre, "_rel"}, m_rel, 0);
        check({pre, "_data"}, m_data, 0);
        check({pre, "_bf"}, m_bf, 0);
        check({pre, "_done"}, m_done, 0);
        check({pre, "_to"}, m_to, 0);
        check({pre, "_busy"}, m_busy, 0);
    endtask

    // nb leading busy polls followed by a ready one, padded with random entries
    task automatic fill_rand(input int nb);
        nib_hi.delete();
        nib_lo.delete();
        for (int i = 0; i < 8; i++) begin
            nib_hi.push_back({(i < nb) ? 1'b1 : 1'b0, 3'($urandom)});
            nib_lo.push_back(4'($urandom));
        end
    endtask

    task automatic run_txn(input bit s, input bit r, input bit p, input int hold, input bit poke);
        int polls, maxp, lat, k, done_k, pulses, ewid, bad_e, bad_hold, first_rise, idx;
        bit ep, to_exp, bf_exp;
        logic [7:0] d_exp;
        maxp = s ? 4 : 255;
        polls = 1;
        if (!r && p)
            while (polls < maxp && nib_hi[polls-1][3]) polls++;
        d_exp  = {nib_hi[polls-1], nib_lo[polls-1]};
        to_exp = !r && p && nib_hi[polls-1][3];
        bf_exp = r ? bf_model[s] : nib_hi[polls-1][3];
        lat    = 1 + T_NIB * 2 * polls + T_GAP * polls + T_POLL * (polls - 1) + (r ? T_REC : 0);

        @(negedge clk);
        sel = s; rs = r; pl = p; st = 1'b1;
        k = 0; done_k = -1; pulses = 0; ewid = 0; bad_e = 0; bad_hold = 0; first_rise = -1; ep = 0;
        while (k < lat + 200) begin
            @(negedge clk);
            k++;
            if (k >= hold) st = 1'b0;
            if (m_done) begin done_k = k; break; end
            if (m_rw !== 1'b1 || m_rel !== 1'b1 || m_rs !== r || m_busy !== 1'b1) bad_hold++;
            if (m_e && !ep) begin
                pulses++;
                if (pulses == 1) first_rise = k;
                idx = (pulses - 1) / 2;
                if (idx < nib_hi.size()) sf = ((pulses - 1) % 2 == 1) ? nib_lo[idx] : nib_hi[idx];
                else sf = 4'($urandom);
                ewid = 1;
            end else if (m_e) begin
                ewid++;
            end else begin
                if (ep && ewid != 12) bad_e++;
                sf = 4'($urandom);
            end
            ep = m_e;
        end
        st = 1'b0;
        check("done_cycle", done_k, lat);
        check("e_setup", first_rise, 3);
        check("e_pulses", pulses, 2 * polls);
        check("e_width", bad_e, 0);
        check("rs_rw_held", bad_hold, 0);
        check("data_out", m_data, d_exp);
        check("busy_flag", m_bf, bf_exp);
        check("timeout", m_to, to_exp);
        check("done_rw", m_rw, 0);
        check("done_rel", m_rel, 0);
        check("done_rs", m_rs, 0);
        bf_model[s] = bf_exp;
        if (poke) begin
            st = 1'b1;
            @(negedge clk);
            st = 1'b0;
            check("poke_busy", m_busy, 0);
        end
        @(negedge clk);
        check("after_done", m_done, 0);
        check("after_busy", m_busy, 0);
        check("after_rel", m_rel, 0);
        repeat (2) @(negedge clk);
        check("no_second", m_busy, 0);
    endtask

    task automatic reset_mid;
        int pulses, ewid;
        bit ep;
        fill_rand(0);
        @(negedge clk);
        sel = 0; rs = 0; pl = 0; st = 1'b1;
        pulses = 0; ewid = 0; ep = 0;
        for (int k = 0; k < 300; k++) begin
            @(negedge clk);
            st = (k < 6);
            if (m_e && !ep) begin pulses++; ewid = 1; sf = 4'hF; end
            else if (m_e) ewid++;
            ep = m_e;
            if (pulses == 2 && ewid == 4) break;
        end
        st = 1'b0;
        check("mid_in_elo", m_e, 1);
        reset = 1'b1;
        @(negedge clk);
        check_zero("mid_rst");
        reset = 1'b0;
        bf_model[0] = 0;
        bf_model[1] = 0;
        repeat (3) @(negedge clk);
        check("mid_idle_rel", m_rel, 0);
        check("mid_idle_busy", m_busy, 0);
    endtask

    initial begin
        bit r, p, s;
        bf_model[0] = 0;
        bf_model[1] = 0;
        repeat (3) @(negedge clk);
        check_zero("rst");
        sel = 1;
        check_zero("rst4");
        sel = 0;
        reset = 1'b0;

        nib_hi.delete(); nib_lo.delete();
        nib_hi.push_back(4'h3); nib_lo.push_back(4'hA);
        run_txn(0, 0, 0, 1, 0);

        nib_hi.delete(); nib_lo.delete();
        nib_hi.push_back(4'h4); nib_lo.push_back(4'h1);
        run_txn(0, 1, 0, 1, 0);

        nib_hi.delete(); nib_lo.delete();
        for (int i = 0; i < 4; i++) begin
            nib_hi.push_back(i < 3 ? 4'h8 : 4'h0);
            nib_lo.push_back(4'($urandom));
        end
        run_txn(0, 0, 1, 3, 0);

        nib_hi.delete(); nib_lo.delete();
        for (int i = 0; i < 6; i++) begin
            nib_hi.push_back(4'hF);
            nib_lo.push_back(4'($urandom));
        end
        run_txn(1, 0, 1, 1, 1);

        for (int t = 0; t < 12; t++) begin
            s = 1'($urandom);
            r = ($urandom_range(0, 3) == 0);
            p = 1'($urandom);
            fill_rand($urandom_range(0, 5));
            run_txn(s, r, p, $urandom_range(1, 4), 1'($urandom));
        end

        reset_mid();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
